// File: rtl/lcd_text_seq_if.sv
// lcd_text_seq_if: host write port plus LCD write-core handshake for lcd_text_seq.
// master is the sequencer view, slave is the host/core view.
interface lcd_text_seq_if;
  logic       iWR_EN;
  logic [4:0] iWR_ADDR;
  logic [7:0] iWR_DATA;
  logic       oINIT_DONE;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_START;
  logic       iLCD_DONE;
  modport master (
    input  iWR_EN, iWR_ADDR, iWR_DATA, iLCD_DONE,
    output oINIT_DONE, oLCD_DATA, oLCD_RS, oLCD_START
  );
  modport slave (
    output iWR_EN, iWR_ADDR, iWR_DATA, iLCD_DONE,
    input  oINIT_DONE, oLCD_DATA, oLCD_RS, oLCD_START
  );
endinterface

// File: rtl/lcd_text_seq.sv
// lcd_text_seq: HD44780 init then 2x16 refresh of a 32-byte host buffer through an LCD write core.
// LCD_CONT_REFRESH_EN: refresh continuously instead of only when the buffer is dirty.
module lcd_text_seq #(
  parameter logic [23:0] PWRUP_CYCLES = 24'd1000000,
  parameter logic [23:0] CMD_CYCLES   = 24'd2500,
  parameter logic [23:0] CLEAR_CYCLES = 24'd100000
) (
  input logic          iCLK,
  input logic          iRST_N,
  lcd_text_seq_if.master bus
);
`ifdef LCD_CONT_REFRESH_EN
  localparam logic CONT = 1'b1;
`else
  localparam logic CONT = 1'b0;
`endif
  typedef enum logic [2:0] {PWRUP, SETUP, START, WAIT_LO, WAIT_HI, DELAY, NEXT, IDLE} state_t;
  state_t      r_state, w_state;
  logic [23:0] r_cnt, w_cnt;
  logic [1:0]  r_step, w_step;
  logic [5:0]  r_item, w_item;
  logic        r_init, w_init;
  logic        r_dirty, w_dirty;
  logic        r_rs, w_rs;
  logic        r_start, w_start;
  logic [7:0]  r_data, w_data;
  logic [7:0]  r_mem [32];
  logic [4:0]  w_addr;
  logic [7:0]  w_item_data;
  logic        w_item_rs;
  logic [23:0] w_lim;
  always_ff @(posedge iCLK)
    if (bus.iWR_EN) r_mem[bus.iWR_ADDR] <= bus.iWR_DATA;
  // items 1-16 map to bytes 0-15, items 18-33 to bytes 16-31
  always_comb begin
    w_addr      = (r_item > 6'd17) ? 5'(r_item - 6'd2) : 5'(r_item - 6'd1);
    w_item_rs   = r_init && r_item != 6'd0 && r_item != 6'd17;
    w_item_data = !r_init ? (r_step == 2'd0 ? 8'h38 : r_step == 2'd1 ? 8'h0C : r_step == 2'd2 ? 8'h01 : 8'h06)
                : r_item == 6'd0 ? 8'h80 : r_item == 6'd17 ? 8'hC0 : r_mem[w_addr];
    w_lim       = (!r_rs && r_data == 8'h01) ? CLEAR_CYCLES - 24'd1 : CMD_CYCLES - 24'd1;
  end
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_step  = r_step;
    w_item  = r_item;
    w_init  = r_init;
    w_data  = r_data;
    w_rs    = r_rs;
    w_start = r_start;
    w_dirty = r_dirty | bus.iWR_EN;
    case (r_state)
      PWRUP: begin
        w_cnt   = (r_cnt == PWRUP_CYCLES - 24'd1) ? 24'd0 : r_cnt + 24'd1;
        w_state = (r_cnt == PWRUP_CYCLES - 24'd1) ? SETUP : PWRUP;
      end
      SETUP: begin
        w_data  = w_item_data;
        w_rs    = w_item_rs;
        w_dirty = (r_init && r_item == 6'd0) ? bus.iWR_EN : w_dirty;
        w_state = START;
      end
      START: begin
        w_start = 1'b1;
        w_state = WAIT_LO;
      end
      WAIT_LO: w_state = bus.iLCD_DONE ? WAIT_LO : WAIT_HI;
      WAIT_HI: begin
        w_start = bus.iLCD_DONE ? 1'b0 : r_start;
        w_state = bus.iLCD_DONE ? DELAY : WAIT_HI;
      end
      DELAY: begin
        w_cnt   = (r_cnt == w_lim) ? 24'd0 : r_cnt + 24'd1;
        w_state = (r_cnt == w_lim) ? NEXT : DELAY;
      end
      NEXT: begin
        w_step  = r_init ? r_step : r_step + 2'd1;
        w_init  = r_init | (r_step == 2'd3);
        w_item  = (r_init && r_item != 6'd33) ? r_item + 6'd1 : 6'd0;
        w_state = (r_init && r_item == 6'd33 && !CONT) ? IDLE : SETUP;
      end
      IDLE: w_state = r_dirty ? SETUP : IDLE;
      default: w_state = PWRUP;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      r_state <= PWRUP;
      r_cnt   <= '0;
      r_step  <= '0;
      r_item  <= '0;
      r_init  <= 1'b0;
      r_dirty <= 1'b1;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_step  <= w_step;
      r_item  <= w_item;
      r_init  <= w_init;
      r_dirty <= w_dirty;
      r_data  <= w_data;
      r_rs    <= w_rs;
      r_start <= w_start;
    end
  assign bus.oLCD_DATA  = r_data;
  assign bus.oLCD_RS    = r_rs;
  assign bus.oLCD_START = r_start;
  assign bus.oINIT_DONE = r_init;
endmodule

// File: tb/tb_lcd_text_seq.sv
// tb_lcd_text_seq: scoreboard bench for lcd_text_seq with a CLK_Divide=4 write-core model.
module tb_lcd_text_seq;
  localparam int PW = 100, CM = 10, CL = 50, DIV = 4;
  typedef struct { logic [8:0] v; int cyc; logic idone; } obs_t;
  logic iCLK = 0, iRST_N = 0;
  logic core_prev = 0, mon_prev = 0, done = 1;
  int core_cnt = 0, cyc = 0, checks = 0, errors = 0, rel = 0;
  logic [7:0] model [32];
  logic [8:0] q_exp [$];
  obs_t q_obs [$];
  lcd_text_seq_if bus();
  lcd_text_seq #(.PWRUP_CYCLES(24'd100), .CMD_CYCLES(24'd10), .CLEAR_CYCLES(24'd50)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));
  assign bus.iLCD_DONE = done;
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;
  // core: done drops the cycle after the start edge, returns high 2*DIV cycles later
  always @(posedge iCLK) begin
    core_prev <= bus.oLCD_START;
    if (bus.oLCD_START && !core_prev) begin
      done <= 1'b0;
      core_cnt <= 2 * DIV - 1;
    end else if (!done) begin
      if (core_cnt == 0) done <= 1'b1;
      else core_cnt <= core_cnt - 1;
    end
  end
  always @(negedge iCLK) begin
    if (bus.oLCD_START && !mon_prev)
      q_obs.push_back('{v: {bus.oLCD_RS, bus.oLCD_DATA}, cyc: cyc, idone: bus.oINIT_DONE});
    mon_prev <= bus.oLCD_START;
  end
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.iWR_EN = 1'b1; bus.iWR_ADDR = a; bus.iWR_DATA = d; model[a] = d;
    @(negedge iCLK);
    bus.iWR_EN = 1'b0;
  endtask
  task automatic push_init;
    q_exp.push_back(9'h038); q_exp.push_back(9'h00C); q_exp.push_back(9'h001); q_exp.push_back(9'h006);
  endtask
  task automatic push_pass;
    q_exp.push_back(9'h080);
    for (int i = 0; i < 16; i++) q_exp.push_back({1'b1, model[i]});
    q_exp.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) q_exp.push_back({1'b1, model[i]});
  endtask
  task automatic wait_obs(input int n, output bit ok);
    for (int i = 0; i < 20000 && q_obs.size() < n; i++) @(posedge iCLK);
    ok = q_obs.size() >= n;
  endtask
  task automatic test_reset;
    bus.iWR_EN = 0; bus.iWR_ADDR = 0; bus.iWR_DATA = 0; iRST_N = 0;
    repeat (3) @(negedge iCLK);
    checks++;
    if ({bus.oLCD_START, bus.oLCD_RS, bus.oINIT_DONE, bus.oLCD_DATA} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b rs=%b idone=%b data=%h, want all 0",
               bus.oLCD_START, bus.oLCD_RS, bus.oINIT_DONE, bus.oLCD_DATA);
    end
    iRST_N = 1; rel = cyc;
  endtask
  task automatic test_init_hello;
    bit ok; obs_t o; logic [8:0] e; int c [5]; logic id [5];
    for (int i = 0; i < 32; i++) wr(5'(i), 8'h00);
    wr(0, 8'h48); wr(1, 8'h45); wr(2, 8'h4C); wr(3, 8'h4C); wr(4, 8'h4F); wr(31, 8'h21);
    push_init; push_pass;
    wait_obs(38, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout: got %0d items, want 38", q_obs.size()); end
    for (int i = 0; i < 5; i++) begin c[i] = 0; id[i] = 1'bx; end
    for (int i = 0; i < 38 && q_obs.size() > 0 && q_exp.size() > 0; i++) begin
      o = q_obs.pop_front(); e = q_exp.pop_front();
      if (i < 5) begin c[i] = o.cyc; id[i] = o.idone; end
      checks++;
      if (o.v !== e) begin errors++; $display("FAIL init_item %0d: got %h want %h", i, o.v, e); end
    end
    checks++;
    if (c[0] - rel < PW) begin errors++; $display("FAIL pwrup_wait: got %0d cycles, want >= %0d", c[0] - rel, PW); end
    checks++;
    if ((c[3] - c[2]) - (c[2] - c[1]) != CL - CM) begin
      errors++; $display("FAIL clear_gap: got extra %0d, want %0d", (c[3] - c[2]) - (c[2] - c[1]), CL - CM);
    end
    checks++;
    if (c[2] - c[1] < 1 + CM) begin errors++; $display("FAIL cmd_gap: got %0d, want >= %0d", c[2] - c[1], 1 + CM); end
    checks++;
    if (id[3] !== 1'b0 || id[4] !== 1'b1) begin
      errors++; $display("FAIL init_done_edge: got %b/%b at 0x06/0x80, want 0/1", id[3], id[4]);
    end
    checks++;
    if (bus.oINIT_DONE !== 1'b1) begin errors++; $display("FAIL init_done_hold: got %b want 1", bus.oINIT_DONE); end
  endtask
  task automatic test_idle;
    bit ok; obs_t o; logic [8:0] e;
    repeat (1000) @(negedge iCLK);
    checks++;
    if (q_obs.size() != 0) begin errors++; $display("FAIL idle_quiet: got %0d starts, want 0", q_obs.size()); end
    wr(16, 8'h41);
    push_pass;
    wait_obs(34, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_pass_timeout: got %0d items, want 34", q_obs.size()); end
    for (int i = 0; i < 34 && q_obs.size() > 0 && q_exp.size() > 0; i++) begin
      o = q_obs.pop_front(); e = q_exp.pop_front();
      checks++;
      if (o.v !== e) begin errors++; $display("FAIL idle_item %0d: got %h want %h", i, o.v, e); end
    end
    repeat (1000) @(negedge iCLK);
    checks++;
    if (q_obs.size() != 0) begin errors++; $display("FAIL single_pass: got %0d extra starts, want 0", q_obs.size()); end
  endtask
  task automatic test_mid_write;
    bit ok; obs_t o; logic [8:0] e;
    @(negedge iCLK);
    wr(5, 8'h57);
    push_pass;
    wait_obs(11, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_item10_timeout: got %0d items, want 11", q_obs.size()); end
    @(negedge iCLK);
    wr(3, 8'h5A);
    push_pass;
    wait_obs(68, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_pass_timeout: got %0d items, want 68", q_obs.size()); end
    for (int i = 0; i < 68 && q_obs.size() > 0 && q_exp.size() > 0; i++) begin
      o = q_obs.pop_front(); e = q_exp.pop_front();
      checks++;
      if (o.v !== e) begin errors++; $display("FAIL mid_item %0d: got %h want %h", i, o.v, e); end
    end
    repeat (1000) @(negedge iCLK);
    checks++;
    if (q_obs.size() != 0) begin errors++; $display("FAIL mid_quiet: got %0d extra starts, want 0", q_obs.size()); end
  endtask
  task automatic test_cont_refresh;
    bit ok; obs_t o; logic [8:0] e; int c [68];
    push_pass; push_pass;
    wait_obs(68, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_timeout: got %0d items, want 68", q_obs.size()); end
    for (int i = 0; i < 68; i++) c[i] = 0;
    for (int i = 0; i < 68 && q_obs.size() > 0 && q_exp.size() > 0; i++) begin
      o = q_obs.pop_front(); e = q_exp.pop_front(); c[i] = o.cyc;
      checks++;
      if (o.v !== e) begin errors++; $display("FAIL cont_item %0d: got %h want %h", i, o.v, e); end
    end
    checks++;
    if (c[34] - c[33] != c[33] - c[32]) begin
      errors++; $display("FAIL cont_wrap_gap: got %0d, want %0d", c[34] - c[33], c[33] - c[32]);
    end
  endtask
  task automatic test_reset_mid;
    bit ok; obs_t o; logic [8:0] e; int c0;
    @(negedge iCLK);
    q_obs.delete(); q_exp.delete();
    wr(7, 8'h52);
    wait_obs(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_pass_timeout: got %0d items, want 1", q_obs.size()); end
    repeat (3) @(posedge iCLK);
    #2;
    checks++;
    if (bus.oLCD_START !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL rst_in_wait_hi: got start=%b done=%b, want 1/0", bus.oLCD_START, done);
    end
    iRST_N = 0;
    #1;
    checks++;
    if (bus.oLCD_START !== 1'b0 || bus.oINIT_DONE !== 1'b0) begin
      errors++; $display("FAIL rst_async: got start=%b idone=%b, want 0/0", bus.oLCD_START, bus.oINIT_DONE);
    end
    @(negedge iCLK);
    iRST_N = 1; rel = cyc;
    q_obs.delete(); q_exp.delete();
    push_init; push_pass;
    wait_obs(38, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_reinit_timeout: got %0d items, want 38", q_obs.size()); end
    c0 = 0;
    for (int i = 0; i < 38 && q_obs.size() > 0 && q_exp.size() > 0; i++) begin
      o = q_obs.pop_front(); e = q_exp.pop_front();
      if (i == 0) c0 = o.cyc;
      checks++;
      if (o.v !== e) begin errors++; $display("FAIL rst_item %0d: got %h want %h", i, o.v, e); end
    end
    checks++;
    if (c0 - rel < PW) begin errors++; $display("FAIL rst_pwrup: got %0d cycles, want >= %0d", c0 - rel, PW); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_init_hello;
`ifdef LCD_CONT_REFRESH_EN
    test_cont_refresh;
`else
    test_idle;
    test_mid_write;
`endif
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
